// File: rtl/cosim_seq_pkg.sv
// Shared types and LFSR helper for the golden-vs-netlist vector sequencer.
package cosim_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST1 = 3'd1,
    REL1 = 3'd2,
    RAND = 3'd3,
    RST2 = 3'd4,
    REL2 = 3'd5,
    DIR  = 3'd6,
    DONE = 3'd7
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // One step of the right-shifting Galois LFSR; taps fold in when the outgoing bit is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/cosim_lfsr32.sv
// 32-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module cosim_lfsr32
  import cosim_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/cosim_vector_sequencer.sv
// Drives shared reset/stimulus into golden and netlist copies, compares their outputs
// after a settle window and accumulates pass/fail statistics.
module cosim_vector_sequencer
  import cosim_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned NUM_RANDOM    = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED     = 32'h1,
  parameter logic [31:0] DIRECTED_VEC  = 32'habcdefab,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] golden_out,
  input  logic [WIDTH-1:0] netlist_out,
  output logic             dut_rst,
  output logic [WIDTH-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam int unsigned SLOT_W = $clog2(NUM_RANDOM + 1);
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic              dut_rst_d;
  logic [WIDTH-1:0]  dut_in_d;
  logic              busy_d, done_d, pass_d;
  logic [CNT_W-1:0]  mismatch_d, vec_d, first_fail_d;

  logic [31:0]       lfsr_value;
  logic [31:0]       lfsr_peek_c;
  logic              lfsr_adv_c;
  logic              cmp_c, finish_c, miss_c, slot_end_c;

  cosim_lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv_c),
    .value   (lfsr_value)
  );

  // Next-state, slot timing and result accumulation.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    slot_d       = slot_q;
    dut_rst_d    = dut_rst;
    dut_in_d     = dut_in;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    mismatch_d   = mismatch_count;
    vec_d        = vec_count;
    first_fail_d = first_fail_idx;
    lfsr_adv_c   = 1'b0;
    cmp_c        = 1'b0;
    finish_c     = 1'b0;
    lfsr_peek_c  = lfsr_next(lfsr_value);
    miss_c       = (golden_out != netlist_out);
    slot_end_c   = (settle_q == '0);

    case (state_q)
      IDLE, DONE: begin
        if (state_q == IDLE) begin
          dut_rst_d = 1'b1;
        end else begin
          dut_rst_d = 1'b0;
        end
        dut_in_d = '0;
        if (start) begin
          // RST1 gets one extra cycle: the acceptance edge is its load edge.
          state_d      = RST1;
          settle_d     = SET_W'(SETTLE_CYCLES);
          slot_d       = '0;
          dut_rst_d    = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          mismatch_d   = '0;
          vec_d        = '0;
          first_fail_d = CNT_ONES;
        end
      end

      RST1, RST2: begin
        if (slot_end_c) begin
          cmp_c     = 1'b1;
          state_d   = (state_q == RST1) ? REL1 : REL2;
          dut_rst_d = 1'b0;
          dut_in_d  = '0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      REL1: begin
        state_d  = RAND;
        slot_d   = '0;
        settle_d = SET_W'(SETTLE_CYCLES - 1);
        dut_in_d = lfsr_value[WIDTH-1:0];
      end

      RAND: begin
        if (slot_end_c) begin
          cmp_c      = 1'b1;
          lfsr_adv_c = 1'b1;
          settle_d   = SET_W'(SETTLE_CYCLES - 1);
          if (slot_q == SLOT_W'(NUM_RANDOM - 1)) begin
            state_d   = RST2;
            dut_rst_d = 1'b1;
            dut_in_d  = '0;
          end else begin
            slot_d   = slot_q + SLOT_W'(1);
            dut_in_d = lfsr_peek_c[WIDTH-1:0];
          end
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      REL2: begin
        state_d  = DIR;
        settle_d = SET_W'(SETTLE_CYCLES - 1);
        dut_in_d = DIRECTED_VEC[WIDTH-1:0];
      end

      DIR: begin
        if (slot_end_c) begin
          cmp_c    = 1'b1;
          finish_c = 1'b1;
          state_d  = DONE;
          dut_in_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // first_fail_idx captures the index before vec_count moves past this compare.
    if (cmp_c) begin
      vec_d = vec_count + CNT_W'(1);
      if (miss_c) begin
        if (mismatch_count == '0) begin
          first_fail_d = vec_count;
        end
        if (mismatch_count != CNT_ONES) begin
          mismatch_d = mismatch_count + CNT_W'(1);
        end
      end
    end

    if (finish_c) begin
      pass_d = (mismatch_d == '0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      slot_q         <= '0;
      dut_rst        <= 1'b1;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      vec_count      <= '0;
      first_fail_idx <= CNT_ONES;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      slot_q         <= slot_d;
      dut_rst        <= dut_rst_d;
      dut_in         <= dut_in_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      mismatch_count <= mismatch_d;
      vec_count      <= vec_d;
      first_fail_idx <= first_fail_d;
    end
  end

endmodule
